// File: rtl/spi_pkg.sv
// Shared SPI definitions: receiver state encoding, opcodes and phase lengths.
// The stimulus master uses the same opcodes.
package spi_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_CMD     = 3'd1,
    ST_ADDR    = 3'd2,
    ST_DUMMY   = 3'd3,
    ST_DATA_WR = 3'd4,
    ST_DATA_RD = 3'd5,
    ST_DRAIN   = 3'd6
  } spi_state_e;

  localparam logic [7:0] CMD_WRITE = 8'h02;
  localparam logic [7:0] CMD_READ  = 8'h0B;

  localparam int CMD_LEN   = 8;
  localparam int ADDR_LEN  = 32;
  localparam int DUMMY_LEN = 34;
  localparam int DATA_LEN  = 32;

  // Terminal value of the 6-bit phase counter for a phase of len bits.
  function automatic logic [5:0] last_bit(input int len);
    return 6'(len - 1);
  endfunction

endpackage

// File: rtl/spi_slave_rx_edge.sv
// spi_edge_det: delays the SPI clock by one clk_i register and flags its edges.
module spi_edge_det (
  input  logic clk_i,
  input  logic rst_i,
  input  logic sclk_i,
  output logic rise_o,
  output logic fall_o
);

  logic sclk_d;
  logic sclk_q;

  // Next value of the delayed SPI clock.
  always_comb begin
    sclk_d = sclk_i;
  end

  // Previous-sample register of the SPI clock.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sclk_q <= 1'b0;
    end else begin
      sclk_q <= sclk_d;
    end
  end

  assign rise_o = sclk_i & ~sclk_q;
  assign fall_o = ~sclk_i & sclk_q;

endmodule

// File: rtl/spi_slave_rx.sv
// SPI target: deserializes CMD/ADDR/DUMMY/DATA frames into single-word memory
// requests and shifts read data back out on MISO.
module spi_slave_rx #(
  parameter int         DUMMY_BITS = spi_pkg::DUMMY_LEN,
  parameter logic [7:0] CMD_WRITE  = spi_pkg::CMD_WRITE,
  parameter logic [7:0] CMD_READ   = spi_pkg::CMD_READ
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        spi_sclk,
  input  logic        spi_sdi,
  input  logic        spi_cs,
  output logic        spi_sdo_o,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  input  logic [31:0] mem_rdata_i,
  input  logic        mem_rvalid_i,
  output logic        err_o,
  output logic [7:0]  frame_cnt_o
);

  import spi_pkg::*;

  localparam logic [5:0] CMD_LAST   = last_bit(CMD_LEN);
  localparam logic [5:0] ADDR_LAST  = last_bit(ADDR_LEN);
  localparam logic [5:0] DUMMY_LAST = last_bit(DUMMY_BITS);
  localparam logic [5:0] DATA_LAST  = last_bit(DATA_LEN);

  logic        rise_s;
  logic        fall_s;

  spi_state_e  state_q, state_d;
  logic [5:0]  bit_cnt_q, bit_cnt_d;
  logic [31:0] shift_q, shift_d;
  logic        is_read_q, is_read_d;
  logic [31:0] rd_buf_q, rd_buf_d;
  logic        rv_seen_q, rv_seen_d;
  logic        armed_q, armed_d;
  logic        sdo_q, sdo_d;
  logic        req_q, req_d;
  logic        we_q, we_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic        err_q, err_d;
  logic [7:0]  frame_cnt_q, frame_cnt_d;

  logic [31:0] bit_in_s;
  logic [31:0] rd_next_s;
  logic        seen_next_s;

  spi_edge_det u_edge (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .sclk_i (spi_sclk),
    .rise_o (rise_s),
    .fall_o (fall_s)
  );

  // Frame sequencing, request generation and MISO shifting.
  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    is_read_d   = is_read_q;
    rd_buf_d    = rd_buf_q;
    rv_seen_d   = rv_seen_q;
    armed_d     = armed_q;
    sdo_d       = sdo_q;
    req_d       = 1'b0;
    we_d        = we_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    err_d       = 1'b0;
    frame_cnt_d = frame_cnt_q;
    bit_in_s    = {shift_q[30:0], spi_sdi};
    rd_next_s   = rd_buf_q;
    seen_next_s = rv_seen_q;

    if (rise_s && !spi_cs) begin
      shift_d = bit_in_s;
    end else begin
      shift_d = shift_q;
    end

    if (spi_cs) begin
      // A frame only starts after CS has been seen high, so a frame cut by reset is drained.
      state_d   = ST_IDLE;
      bit_cnt_d = 6'd0;
      armed_d   = 1'b1;
      if ((state_q == ST_IDLE) || (state_q == ST_DRAIN) ||
          ((state_q == ST_CMD) && (bit_cnt_q == 6'd0))) begin
        err_d = 1'b0;
      end else begin
        err_d = 1'b1;
      end
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (armed_q) begin
            state_d   = ST_CMD;
            bit_cnt_d = rise_s ? 6'd1 : 6'd0;
          end else begin
            state_d = ST_DRAIN;
          end
        end

        ST_CMD: begin
          if (rise_s && (bit_cnt_q == CMD_LAST)) begin
            bit_cnt_d = 6'd0;
            if (bit_in_s[7:0] == CMD_WRITE) begin
              is_read_d = 1'b0;
              state_d   = ST_ADDR;
            end else if (bit_in_s[7:0] == CMD_READ) begin
              is_read_d = 1'b1;
              state_d   = ST_ADDR;
            end else begin
              err_d   = 1'b1;
              state_d = ST_DRAIN;
            end
          end else if (rise_s) begin
            bit_cnt_d = bit_cnt_q + 6'd1;
          end else begin
            bit_cnt_d = bit_cnt_q;
          end
        end

        ST_ADDR: begin
          if (rise_s && (bit_cnt_q == ADDR_LAST)) begin
            bit_cnt_d = 6'd0;
            addr_d    = bit_in_s;
            if (is_read_q) begin
              req_d     = 1'b1;
              we_d      = 1'b0;
              rv_seen_d = 1'b0;
              state_d   = ST_DUMMY;
            end else begin
              state_d = ST_DATA_WR;
            end
          end else if (rise_s) begin
            bit_cnt_d = bit_cnt_q + 6'd1;
          end else begin
            bit_cnt_d = bit_cnt_q;
          end
        end

        ST_DUMMY: begin
          if (mem_rvalid_i && !rv_seen_q) begin
            rd_next_s   = mem_rdata_i;
            seen_next_s = 1'b1;
          end else begin
            rd_next_s   = rd_buf_q;
            seen_next_s = rv_seen_q;
          end
          if (rise_s && (bit_cnt_q == DUMMY_LAST)) begin
            bit_cnt_d = 6'd0;
            state_d   = ST_DATA_RD;
            if (!seen_next_s) begin
              err_d     = 1'b1;
              rd_next_s = 32'd0;
            end else begin
              err_d = 1'b0;
            end
            sdo_d    = rd_next_s[31];
            rd_buf_d = {rd_next_s[30:0], 1'b0};
          end else if (rise_s) begin
            bit_cnt_d = bit_cnt_q + 6'd1;
            rd_buf_d  = rd_next_s;
          end else begin
            rd_buf_d = rd_next_s;
          end
          rv_seen_d = seen_next_s;
        end

        ST_DATA_WR: begin
          if (rise_s && (bit_cnt_q == DATA_LAST)) begin
            bit_cnt_d   = 6'd0;
            req_d       = 1'b1;
            we_d        = 1'b1;
            wdata_d     = bit_in_s;
            frame_cnt_d = frame_cnt_q + 8'd1;
            state_d     = ST_CMD;
          end else if (rise_s) begin
            bit_cnt_d = bit_cnt_q + 6'd1;
          end else begin
            bit_cnt_d = bit_cnt_q;
          end
        end

        ST_DATA_RD: begin
          // MSB is already on MISO at entry; the fall before the first data rise must not shift.
          if (fall_s && (bit_cnt_q != 6'd0)) begin
            sdo_d    = rd_buf_q[31];
            rd_buf_d = {rd_buf_q[30:0], 1'b0};
          end else begin
            sdo_d    = sdo_q;
            rd_buf_d = rd_buf_q;
          end
          if (rise_s && (bit_cnt_q == DATA_LAST)) begin
            bit_cnt_d   = 6'd0;
            frame_cnt_d = frame_cnt_q + 8'd1;
            state_d     = ST_CMD;
          end else if (rise_s) begin
            bit_cnt_d = bit_cnt_q + 6'd1;
          end else begin
            bit_cnt_d = bit_cnt_q;
          end
        end

        ST_DRAIN: begin
          state_d = ST_DRAIN;
        end

        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  // State and output registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= ST_IDLE;
      bit_cnt_q   <= 6'd0;
      shift_q     <= 32'd0;
      is_read_q   <= 1'b0;
      rd_buf_q    <= 32'd0;
      rv_seen_q   <= 1'b0;
      armed_q     <= 1'b0;
      sdo_q       <= 1'b0;
      req_q       <= 1'b0;
      we_q        <= 1'b0;
      addr_q      <= 32'd0;
      wdata_q     <= 32'd0;
      err_q       <= 1'b0;
      frame_cnt_q <= 8'd0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      is_read_q   <= is_read_d;
      rd_buf_q    <= rd_buf_d;
      rv_seen_q   <= rv_seen_d;
      armed_q     <= armed_d;
      sdo_q       <= sdo_d;
      req_q       <= req_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      err_q       <= err_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end

  assign spi_sdo_o   = sdo_q;
  assign mem_req_o   = req_q;
  assign mem_we_o    = we_q;
  assign mem_addr_o  = addr_q;
  assign mem_wdata_o = wdata_q;
  assign err_o       = err_q;
  assign frame_cnt_o = frame_cnt_q;

endmodule

// File: tb/tb_spi_slave_rx.sv
// Randomized bench for spi_slave_rx: a bit-level SPI master, a memory responder
// and a frame-level reference model of requests, errors, MISO data and frame count.
module tb_spi_slave_rx;

  localparam int         DUMMY  = 34;
  localparam logic [7:0] CMD_WR = 8'h02;
  localparam logic [7:0] CMD_RD = 8'h0B;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } req_t;

  logic        clk = 1'b0;
  logic        rst_i;
  logic        spi_sclk, spi_sdi, spi_cs;
  logic        spi_sdo_o, mem_req_o, mem_we_o, err_o;
  logic [31:0] mem_addr_o, mem_wdata_o;
  logic [31:0] mem_rdata_i = 32'd0;
  logic        mem_rvalid_i = 1'b0;
  logic [7:0]  frame_cnt_o;

  int n_chk = 0;
  int n_bad = 0;
  int cyc = 0;
  int half_cyc = 2;
  int last_raise = 0;

  // environment state owned by the monitor process
  logic        obs_we   [0:2047];
  logic [31:0] obs_addr [0:2047];
  logic [31:0] obs_wdata[0:2047];
  int obs_n = 0;
  int req_cyc = 0;
  int err_seen = 0;
  int both_cnt = 0;
  int rsp_cnt = 0;
  logic [31:0] rsp_data = 32'd0;

  // model state owned by the stimulus process
  int   rsp_delay = 0;
  int   obs_rd = 0;
  req_t exp_q[$];
  int   exp_err = 0;
  int   exp_frames = 0;

  spi_slave_rx dut (
    .clk_i        (clk),
    .rst_i        (rst_i),
    .spi_sclk     (spi_sclk),
    .spi_sdi      (spi_sdi),
    .spi_cs       (spi_cs),
    .spi_sdo_o    (spi_sdo_o),
    .mem_req_o    (mem_req_o),
    .mem_we_o     (mem_we_o),
    .mem_addr_o   (mem_addr_o),
    .mem_wdata_o  (mem_wdata_o),
    .mem_rdata_i  (mem_rdata_i),
    .mem_rvalid_i (mem_rvalid_i),
    .err_o        (err_o),
    .frame_cnt_o  (frame_cnt_o)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'd100) return 32'hDEAD_BEEF;
    else return (a * 32'h9E37_79B1) + 32'h1234_5678;
  endfunction

  // Request/error monitor and delayed read-data responder.
  always @(negedge clk) begin
    mem_rvalid_i = 1'b0;
    if (rsp_cnt > 0) begin
      rsp_cnt = rsp_cnt - 1;
      if (rsp_cnt == 0) begin
        mem_rvalid_i = 1'b1;
        mem_rdata_i  = rsp_data;
      end
    end
    if (mem_req_o) begin
      obs_we[obs_n]    = mem_we_o;
      obs_addr[obs_n]  = mem_addr_o;
      obs_wdata[obs_n] = mem_wdata_o;
      obs_n   = obs_n + 1;
      req_cyc = cyc;
      if (!mem_we_o && (rsp_delay > 0)) begin
        rsp_cnt  = rsp_delay;
        rsp_data = mem_word(mem_addr_o);
      end
    end
    if (err_o) err_seen = err_seen + 1;
    if (err_o && mem_req_o) both_cnt = both_cnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk = n_chk + 1;
    if (got !== exp) begin
      n_bad = n_bad + 1;
      $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
    end
  endtask

  task automatic spi_bit(input logic b, output logic miso);
    spi_sdi  = b;
    spi_sclk = 1'b0;
    repeat (half_cyc) @(negedge clk);
    miso       = spi_sdo_o;
    last_raise = cyc;
    spi_sclk   = 1'b1;
    repeat (half_cyc) @(negedge clk);
  endtask

  task automatic send_word(input logic [31:0] v, input int nbits);
    logic m;
    for (int i = nbits - 1; i >= 0; i--) spi_bit(v[i], m);
  endtask

  task automatic cs_begin();
    spi_cs = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic cs_end();
    spi_sclk = 1'b0;
    @(negedge clk);
    spi_cs = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, " sdo"},   32'(spi_sdo_o),   32'd0);
    chk({tag, " req"},   32'(mem_req_o),   32'd0);
    chk({tag, " we"},    32'(mem_we_o),    32'd0);
    chk({tag, " addr"},  mem_addr_o,       32'd0);
    chk({tag, " wdata"}, mem_wdata_o,      32'd0);
    chk({tag, " err"},   32'(err_o),       32'd0);
    chk({tag, " fcnt"},  32'(frame_cnt_o), 32'd0);
  endtask

  task automatic verify(input string tag);
    req_t e;
    chk({tag, " nreq"}, 32'(obs_n - obs_rd), 32'(exp_q.size()));
    while ((obs_rd < obs_n) && (exp_q.size() > 0)) begin
      e = exp_q.pop_front();
      chk({tag, " we"},   32'(obs_we[obs_rd]), 32'(e.we));
      chk({tag, " addr"}, obs_addr[obs_rd],    e.addr);
      if (e.we) chk({tag, " wdata"}, obs_wdata[obs_rd], e.wdata);
      obs_rd = obs_rd + 1;
    end
    obs_rd = obs_n;
    exp_q.delete();
    chk({tag, " errs"},   32'(err_seen),    32'(exp_err));
    chk({tag, " frames"}, 32'(frame_cnt_o), 32'(exp_frames % 256));
  endtask

  // kind 0 = write, 1 = read, 2 = bad opcode (data[7:0]); abort_at < 0 sends the whole frame.
  task automatic run_frame(input int kind, input logic [31:0] addr, input logic [31:0] data,
                           input int delay, input int abort_at);
    logic        bits[$];
    logic [7:0]  cmd;
    logic [31:0] rd_word;
    logic        miso;
    int          n, total, lat_ref;
    rd_word = 32'd0;
    lat_ref = 0;
    if (kind == 0) cmd = CMD_WR;
    else if (kind == 1) cmd = CMD_RD;
    else cmd = data[7:0];
    for (int i = 7; i >= 0; i--) bits.push_back(cmd[i]);
    if (kind == 2) begin
      for (int i = 0; i < 40; i++) bits.push_back(1'($urandom));
    end else begin
      for (int i = 31; i >= 0; i--) bits.push_back(addr[i]);
    end
    if (kind == 0) for (int i = 31; i >= 0; i--) bits.push_back(data[i]);
    if (kind == 1) begin
      for (int i = 0; i < DUMMY; i++) bits.push_back(1'($urandom));
      for (int i = 0; i < 32; i++) bits.push_back(1'b0);
    end
    total = bits.size();
    n = (abort_at >= 0) ? abort_at : total;
    rsp_delay = delay;
    for (int i = 0; i < n; i++) begin
      spi_bit(bits[i], miso);
      if ((kind == 1) && (i >= 40 + DUMMY)) rd_word = {rd_word[30:0], miso};
      if (((kind == 0) && (i == 71)) || ((kind == 1) && (i == 39))) lat_ref = last_raise;
    end
    #1;
    if (n > 0) begin
      if (kind == 0) begin
        if (n == total) begin
          exp_q.push_back('{1'b1, addr, data});
          exp_frames = exp_frames + 1;
          chk("wr_latency", 32'(req_cyc - lat_ref), 32'd1);
        end else begin
          exp_err = exp_err + 1;
        end
      end else if (kind == 1) begin
        if (n >= 40) begin
          exp_q.push_back('{1'b0, addr, 32'd0});
          chk("rd_latency", 32'(req_cyc - lat_ref), 32'd1);
        end
        if ((delay == 0) && (n >= 40 + DUMMY)) exp_err = exp_err + 1;
        if (n == total) begin
          exp_frames = exp_frames + 1;
          chk("miso_word", rd_word, (delay > 0) ? mem_word(addr) : 32'd0);
        end else begin
          exp_err = exp_err + 1;
        end
      end else begin
        exp_err = exp_err + 1;
      end
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached, total=%0d", n_chk);
    $fatal(1, "watchdog");
  end

  initial begin
    int nf, kind, ab, dly;
    logic [7:0] bad;
    rst_i = 1'b1; spi_cs = 1'b1; spi_sclk = 1'b0; spi_sdi = 1'b0;
    repeat (4) @(negedge clk);
    check_reset_outputs("reset");
    rst_i = 1'b0;
    repeat (3) @(negedge clk);

    cs_begin(); run_frame(0, 32'd100, 32'd100, 0, -1); cs_end(); verify("write");
    cs_begin(); run_frame(1, 32'd100, 32'd0, 4, -1); cs_end(); verify("read");
    cs_begin();
    run_frame(0, 32'd100, 32'd100, 0, -1);
    run_frame(1, 32'd100, 32'd0, 4, -1);
    cs_end(); verify("b2b");
    cs_begin(); run_frame(2, 32'd0, 32'd5, 0, -1); cs_end(); verify("badop");
    cs_begin(); run_frame(0, 32'hCAFE_0001, 32'h1, 0, 24); cs_end(); verify("early_cs");
    cs_begin(); run_frame(0, 32'h0000_0040, 32'hA5A5_5A5A, 0, -1); cs_end(); verify("after_early");
    cs_begin(); run_frame(1, 32'h0BAD_F00D, 32'd0, 0, -1); cs_end(); verify("timeout");

    cs_begin();
    send_word(32'(CMD_WR), 8);
    send_word(32'h0000_0155, 10);
    rst_i = 1'b1;
    @(negedge clk);
    check_reset_outputs("midreset");
    rst_i = 1'b0;
    exp_frames = 0;
    send_word($urandom, 22);
    send_word($urandom, 32);
    cs_end(); verify("post_reset");

    for (int g = 0; g < 20; g++) begin
      nf = $urandom_range(1, 3);
      cs_begin();
      for (int f = 0; f < nf; f++) begin
        kind = ($urandom_range(0, 1) == 0) ? 0 : 1;
        ab = -1;
        if (f == nf - 1) begin
          if ($urandom_range(0, 3) == 0) ab = $urandom_range(1, (kind == 0) ? 71 : 105);
          else if ($urandom_range(0, 5) == 0) kind = 2;
        end
        dly = ($urandom_range(0, 6) == 0) ? 0 : $urandom_range(1, 2 * DUMMY - 2);
        bad = 8'($urandom);
        if ((bad == CMD_WR) || (bad == CMD_RD)) bad = bad ^ 8'h80;
        run_frame(kind, $urandom, (kind == 2) ? 32'(bad) : $urandom, dly, ab);
      end
      cs_end(); verify("rand");
    end

    half_cyc = 1;
    cs_begin();
    while ((exp_frames % 256) != 255) run_frame(0, $urandom, $urandom, 0, -1);
    cs_end(); verify("cnt255");
    cs_begin();
    repeat (2) run_frame(0, $urandom, $urandom, 0, -1);
    cs_end(); verify("cnt_wrap");

    chk("err_req_exclusive", 32'(both_cnt), 32'd0);
    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule

// File: doc/spi_slave_rx.md
# spi_slave_rx

Bench-side SPI target that sits directly downstream of the SPI stimulus master on the FPGA and consumes its `spi_sclk`/`spi_sdo`/`spi_cs` stream. It deserializes command, address, dummy and data phases and turns each frame into a single-word memory request on a simple request/response port. For read frames it shifts the returned word back out on MISO. It serves as a loopback target and protocol checker for the master before the chip is attached.

## Interface

**Parameters**
- `DUMMY_BITS`, default 34: number of dummy bits between address and data on read frames.
- `CMD_WRITE`, default 8'h02: write-memory opcode.
- `CMD_READ`, default 8'h0B: read-memory opcode.

**Ports**
- Clock and reset: one clock; reset is synchronous and active-high.
  - `clk_i`, in, 1: FPGA clock, the same clock as the master.
  - `rst_i`, in, 1: synchronous reset, active-high.
- SPI side:
  - `spi_sclk`, in, 1: SPI clock from the master, at half the `clk_i` rate or slower.
  - `spi_sdi`, in, 1: serial data from the master (master `spi_sdo`).
  - `spi_cs`, in, 1: chip select, active-low.
  - `spi_sdo_o`, out, 1: MISO, read data MSB first.
- Memory side:
  - `mem_req_o`, out, 1: one-cycle request pulse.
  - `mem_we_o`, out, 1: 1 = write, 0 = read; valid with `mem_req_o`.
  - `mem_addr_o`, out, 32: word address; valid with `mem_req_o`.
  - `mem_wdata_o`, out, 32: write data; valid with `mem_req_o` when `mem_we_o` = 1.
  - `mem_rdata_i`, in, 32: read data.
  - `mem_rvalid_i`, in, 1: one-cycle pulse qualifying `mem_rdata_i`.
- Status:
  - `err_o`, out, 1: one-cycle pulse on a protocol error.
  - `frame_cnt_o`, out, 8: count of completed frames.

## Operation

**Sampling and edges**
- All SPI inputs are synchronous to `clk_i`; no synchronizers.
- `sclk_q` holds `spi_sclk` delayed by one register.
- `rise` = `spi_sclk & ~sclk_q`; `fall` = `~spi_sclk & sclk_q`.
- `spi_sdi` is shifted into a 32-bit shift register, MSB first, on `rise` while `spi_cs` = 0.

**State machine**
- States: IDLE, CMD, ADDR, DUMMY, DATA_WR, DATA_RD, DRAIN. A 6-bit `bit_cnt` counts bits in the current phase.
- IDLE → CMD when `spi_cs` = 0.
- CMD: after 8 bits, decode the opcode.
  - `CMD_WRITE` or `CMD_READ` → ADDR.
  - Any other opcode → pulse `err_o`, go to DRAIN.
- ADDR: after 32 bits, latch `mem_addr_o`.
  - Write frame → DATA_WR.
  - Read frame → pulse `mem_req_o` with `mem_we_o` = 0, go to DUMMY.
- DUMMY: after `DUMMY_BITS` bits → DATA_RD.
  - `mem_rvalid_i` is accepted during DUMMY; the first pulse latches `mem_rdata_i` into `rd_buf`.
  - If no `mem_rvalid_i` has arrived by DUMMY exit: pulse `err_o` and set `rd_buf` = 0.
- DATA_WR: after 32 bits → pulse `mem_req_o` with `mem_we_o` = 1, `mem_wdata_o` = shifted word; increment `frame_cnt_o`; go to CMD.
- DATA_RD: `spi_sdo_o` presents `rd_buf[31]` on DATA_RD entry and shifts left on each `fall`. After 32 `rise`s → increment `frame_cnt_o`, go to CMD.
- CS is held low across back-to-back frames; the next frame's CMD starts immediately after DATA.
- DRAIN: ignore all bits until `spi_cs` = 1.

**CS rules**
- `spi_cs` = 1 in any state → IDLE next cycle.
- `spi_cs` = 1 in IDLE or CMD with `bit_cnt` = 0: clean return, no error.
- `spi_cs` = 1 in any other state or `bit_cnt`: pulse `err_o`, issue no request, leave `frame_cnt_o` unchanged.
- `mem_rvalid_i` outside DUMMY: ignored.
- `frame_cnt_o` wraps 255 → 0.

## Timing

- **Reset values:** `spi_sdo_o` = 0, `mem_req_o` = 0, `mem_we_o` = 0, `mem_addr_o` = 0, `mem_wdata_o` = 0, `err_o` = 0, `frame_cnt_o` = 0, state = IDLE, `sclk_q` = 0.
- **Reset mid-frame:** state returns to IDLE and all outputs take their reset values the next cycle. The current CS-low frame is then drained like an error, but with no `err_o` pulse.
- **Write request latency:** `mem_req_o` asserts the cycle after the `rise` that samples the 32nd data bit.
- **Read request latency:** `mem_req_o` asserts the cycle after the `rise` that samples the 32nd address bit.
- **Read data deadline:** the memory must return `mem_rvalid_i` within `2*DUMMY_BITS - 2` clk cycles of the request.
- `spi_sdo_o` is registered and changes only on `fall` cycles, or on DATA_RD entry.
- `err_o` and `mem_req_o` are single-cycle pulses and never assert in the same cycle.

## Structure

- Shared package `spi_pkg`:
  - State enum.
  - `CMD_WRITE` / `CMD_READ` constants, shared with the master.
  - Phase lengths: 8 / 32 / 34 / 32.
- One natural sub-module, `spi_edge_det`: `sclk_q` register producing `rise` and `fall`.
- The rest is a single FSM plus datapath.

## Test plan

1. **Write frame:** CMD 0x02, ADDR 100, DATA 100 → one `mem_req_o` pulse with `mem_we_o` = 1, `mem_addr_o` = 0x64, `mem_wdata_o` = 0x64; `frame_cnt_o` = 1; no `err_o`.
2. **Read frame:** CMD 0x0B, ADDR 100; memory returns 0xDEADBEEF 4 cycles after the request → `mem_req_o` with `mem_we_o` = 0, `mem_addr_o` = 0x64; `spi_sdo_o` bits, sampled on master rises, read 0xDEADBEEF MSB first.
3. **Back-to-back frames:** the write of scenario 1 then the read of scenario 2 under one CS-low period → two requests in order; `frame_cnt_o` = 2; no `err_o`.
4. **Bad opcode:** CMD 0x05 followed by 40 bits → `err_o` pulses once after bit 8; no `mem_req_o`; IDLE after CS rises.
5. **Early CS release:** `spi_cs` rises after 16 address bits → one `err_o` pulse; no request; IDLE next cycle; `frame_cnt_o` unchanged.
6. **Read timeout and reset:** read frame with no `mem_rvalid_i` → `err_o` at DUMMY exit and `spi_sdo_o` = 0 for all 32 bits. Separately, `rst_i` asserted mid-ADDR → all outputs return to reset values the next cycle.
